simplerisc_imem_loader: RTL and testbench
=========================================

SIMPLERISC_IMEM_LOADER -- requirements
Module: simplerisc_imem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, meaning the number of 32-bit instruction-memory words.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory address width; log2(IMEM_DEPTH).
REQ-003 SHALL have port clk1, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a load session.
REQ-006 SHALL have port s_valid, input, 1 bit: byte-stream data valid.
REQ-007 SHALL have port s_data, input, 8 bits: byte-stream data.
REQ-008 SHALL have port s_ready, output, 1 bit: loader accepts a byte; transfer = s_valid & s_ready at posedge.
REQ-009 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port imem_addr, output, ADDR_W bits: word address.
REQ-011 SHALL have port imem_wdata, output, 32 bits: instruction word.
REQ-012 SHALL have port core_hold, output, 1 bit: holds the pipelined core stalled while loading.
REQ-013 SHALL have port done, output, 1 bit: sticky load-complete flag.
REQ-014 SHALL have port err, output, 1 bit: sticky load-failed flag.

Function
REQ-015 SHALL frame each session as a 16-bit little-endian word count N, then N words of 4 little-endian bytes each.
REQ-016 SHALL implement states IDLE, LEN0, LEN1, DATA, CHK (macro only), DONE, ERR.
REQ-017 SHALL transition on start: IDLE/DONE/ERR -> LEN0, clearing done, err, word index and byte index; start SHALL be ignored in LEN0/LEN1/DATA/CHK.
REQ-018 SHALL transition LEN0 -> LEN1 on transfer, and on the LEN1 transfer: N=0 -> DONE (CHK if enabled); N>IMEM_DEPTH -> ERR; else -> DATA.
REQ-019 SHALL assert s_ready combinationally exactly in LEN0, LEN1, DATA and CHK.
REQ-020 SHALL place byte k (0..3) of a word in bits [8k+7:8k].
REQ-021 SHALL assert imem_we for exactly one cycle, the cycle after byte 3 of word i is accepted, with imem_addr=i and imem_wdata = the assembled word.
REQ-022 SHALL hold imem_addr/imem_wdata stable while imem_we=1, and SHALL zero imem_we outside such cycles.
REQ-023 SHALL go DATA -> DONE (CHK if enabled) in the same cycle as the final word's write.
REQ-024 SHALL accept back-to-back bytes every cycle; s_valid gaps SHALL only delay progress and never corrupt assembly.
REQ-025 SHALL assert core_hold from the cycle after start is accepted until entering DONE; core_hold SHALL stay 1 in ERR.
REQ-026 SHALL assert done only in DONE and err only in ERR; both remain set until the next start.
REQ-027 SHALL let the word index run 0..N-1 with no wrap; N=IMEM_DEPTH writes address IMEM_DEPTH-1 last.

Reset
REQ-028 SHALL, on rst_n low (async, any state, mid-word included), force IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, err=0, and discard partial word and counters.
REQ-029 SHALL keep core_hold=1 in IDLE after reset until a session reaches DONE.

Configuration
REQ-030 SHALL, with SIMPLERISC_LOADER_CHECKSUM_EN defined, expect one extra byte after the payload equal to the XOR of all length and payload bytes, accept it in CHK, and enter DONE on match or ERR on mismatch.
REQ-031 SHALL, without SIMPLERISC_LOADER_CHECKSUM_EN, omit the CHK state and checksum register and enter DONE directly.

Structure
REQ-032 SHALL take the loader state enum, IMEM_DEPTH default and the SimpleRisc opcode constants from shared package simplerisc_pkg.
REQ-033 SHALL instantiate one sub-module, simplerisc_word_packer (byte shift register plus 2-bit byte index, emitting a word_valid pulse).

Verification
REQ-034 SHALL check: start; bytes 02 00, 01 00 00 00, 0D 00 00 68 -> writes addr0=0x00000001, addr1=0x6800000D, done=1, core_hold=0.
REQ-035 SHALL check: length bytes 00 00 -> done=1 with no imem_we pulse (checksum 00 when enabled).
REQ-036 SHALL check: length 0x0401 -> err=1, s_ready=0, core_hold=1, no writes.
REQ-037 SHALL check: randomized s_valid gaps with N=3 -> identical writes to the gap-free run.
REQ-038 SHALL check: rst_n low after 2 bytes of word 0 -> all outputs at reset values; a new session then loads correctly from addr 0.
REQ-039 SHALL check (macro on): correct checksum -> done=1; flipped checksum bit -> err=1.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: loader state encoding, memory sizing defaults, opcodes.
// Optional feature macro: SIMPLERISC_LOADER_CHECKSUM_EN adds the CHK state.
package simplerisc_pkg;

  localparam int IMEM_DEPTH_DEF  = 1024;
  localparam int IMEM_ADDR_W_DEF = 10;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
    ST_CHK  = 3'd4,
`endif
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } loader_state_e;

endpackage

// File: rtl/simplerisc_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word and pulses word_valid
// the cycle after the fourth byte is taken.
module simplerisc_word_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_word_valid;

  // Bytes shift in from the top so byte 0 ends up in [7:0] after four shifts.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else if (clr) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= byte_valid && (r_idx == 2'd3);
      if (byte_valid) begin
        r_shift <= {byte_data, r_shift[31:8]};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  assign byte_idx   = r_idx;
  assign word_valid = r_word_valid;
  assign word_data  = r_shift;

endmodule

// File: rtl/simplerisc_imem_loader.sv
// Byte-stream instruction-memory loader: 16-bit LE word count then N LE words.
// Optional macro SIMPLERISC_LOADER_CHECKSUM_EN appends an XOR checksum byte.
module simplerisc_imem_loader
  import simplerisc_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int ADDR_W     = IMEM_ADDR_W_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  loader_state_e     r_state;
  loader_state_e     w_state_nxt;
  logic [7:0]        r_len_lo;
  logic [ADDR_W-1:0] r_widx;
  logic [ADDR_W-1:0] r_last_idx;

  logic              w_xfer;
  logic              w_session_start;
  logic [15:0]       w_len;
  logic              w_len_too_big;
  logic [ADDR_W-1:0] w_last_idx;
  logic              w_byte_valid;
  logic              w_last_byte;
  logic [1:0]        w_pk_idx;
  logic              w_word_valid;
  logic [31:0]       w_word_data;

`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_xfer          = s_valid && s_ready;
  assign w_session_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERR));
  assign w_len           = {s_data, r_len_lo};
  assign w_len_too_big   = 32'(w_len) > 32'(IMEM_DEPTH);
  assign w_last_idx      = ADDR_W'(w_len - 16'd1);
  assign w_byte_valid    = w_xfer && (r_state == ST_DATA);
  // r_widx already equals the word number when its fourth byte arrives.
  assign w_last_byte     = w_byte_valid && (w_pk_idx == 2'd3) && (r_widx == r_last_idx);

  simplerisc_word_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (w_session_start),
    .byte_valid (w_byte_valid),
    .byte_data  (s_data),
    .byte_idx   (w_pk_idx),
    .word_valid (w_word_valid),
    .word_data  (w_word_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_state_nxt = ST_LEN0;
      end
      ST_LEN0: begin
        if (w_xfer) w_state_nxt = ST_LEN1;
      end
      ST_LEN1: begin
        if (w_xfer) begin
          if (w_len == 16'd0) begin
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
            w_state_nxt = ST_CHK;
`else
            w_state_nxt = ST_DONE;
`endif
          end else if (w_len_too_big) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Leave as the last byte lands so the final write cycle is already post-payload.
        if (w_last_byte) begin
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
          w_state_nxt = ST_CHK;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_xfer) w_state_nxt = (s_data == r_csum) ? ST_DONE : ST_ERR;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len_lo   <= '0;
      r_last_idx <= '0;
      r_widx     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_LEN0) && w_xfer) r_len_lo <= s_data;
      if ((r_state == ST_LEN1) && w_xfer) r_last_idx <= w_last_idx;
      if (w_session_start) begin
        r_widx <= '0;
      end else if (w_word_valid && (r_widx != r_last_idx)) begin
        r_widx <= r_widx + ADDR_W'(1);
      end
    end
  end

`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_session_start) begin
      r_csum <= '0;
    end else if (w_xfer && (r_state != ST_CHK)) begin
      r_csum <= r_csum ^ s_data;
    end
  end
`endif

  always_comb begin
    s_ready = 1'b0;
    case (r_state)
      ST_LEN0, ST_LEN1, ST_DATA: s_ready = 1'b1;
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
      ST_CHK:                    s_ready = 1'b1;
`endif
      default:                   s_ready = 1'b0;
    endcase
  end

  // The core is released only by a completed load; IDLE after reset and ERR keep it held.
  assign core_hold  = (r_state != ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);
  assign imem_we    = w_word_valid;
  assign imem_addr  = r_widx;
  assign imem_wdata = w_word_data;

endmodule

// File: tb/tb_simplerisc_imem_loader.sv
// Self-checking bench for simplerisc_imem_loader: frame-level model plus literal pins.
// Honours SIMPLERISC_LOADER_CHECKSUM_EN by appending the XOR checksum byte.
module tb_simplerisc_imem_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          err;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t ref_q[$];

  always #5 clk1 = ~clk1;

  simplerisc_imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Spec-level frame interpretation: expected writes and final outcome.
  function automatic void model(input byte_q_t b, output bit exp_done, output bit exp_err);
    int n;
    n = int'(b[0]) + 256 * int'(b[1]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      wr_t x;
      x.addr = AW'(w);
      x.data = {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]};
      exp_q.push_back(x);
    end
    exp_done = 1'b1;
  endfunction

  initial begin : cmp_proc
    wr_t e;
    bit  prev_we;
    prev_we = 1'b0;
    forever begin
      @(negedge clk1);
      if (rst_n) begin
        check("core_hold_vs_done", core_hold, !done);
        check("ready_when_finished", s_ready && (done || err), 0);
        if (imem_we) begin
          obs_q.push_back({imem_addr, imem_wdata});
          check("we_single_cycle", prev_we, 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write", imem_addr, imem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", imem_addr, e.addr);
            check("write_data", imem_wdata, e.data);
          end
        end
        prev_we = imem_we;
      end else begin
        prev_we = 1'b0;
      end
    end
  end

  task automatic send(input byte_q_t q, input bit gaps);
    int i;
    int guard;
    bit xfer;
    i = 0;
    guard = 0;
    while (i < q.size() && guard < 30000) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0;
        s_data  = 8'hxx;
      end else begin
        s_valid = 1'b1;
        s_data  = q[i];
      end
      xfer = s_valid && s_ready;
      tick();
      if (xfer) i++;
      guard++;
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
    check("send_all_bytes_accepted", i, q.size());
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_session(input byte_q_t b, input bit gaps, input bit flip, input string tag);
    bit      d;
    bit      e;
    byte_q_t tx;
    logic [7:0] c;
    model(b, d, e);
    tx = b;
    c = 8'h00;
    foreach (b[k]) c ^= b[k];
`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
    if (!e) begin
      if (flip) begin
        c = c ^ 8'h01;
        d = 1'b0;
        e = 1'b1;
      end
      tx.push_back(c);
    end
`endif
    obs_q.delete();
    pulse_start();
    send(tx, gaps);
    repeat (3) tick();
    check({tag, "_done"}, done, d);
    check({tag, "_err"}, err, e);
    check({tag, "_core_hold"}, core_hold, !d);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_hold"}, core_hold, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    byte_q_t b;
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset("por");
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_hold", core_hold, 1);

    // two words, literal pins
    b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h68};
    run_session(b, 1'b0, 1'b0, "basic");
    check("basic_nwrites", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      check("basic_w0", obs_q[0], {10'd0, 32'h00000001});
      check("basic_w1", obs_q[1], {10'd1, 32'h6800000D});
    end
    check("basic_done_lit", done, 1);
    check("basic_hold_lit", core_hold, 0);

    // zero-length session
    b = '{8'h00, 8'h00};
    run_session(b, 1'b0, 1'b0, "zero");
    check("zero_nwrites", obs_q.size(), 0);
    check("zero_done_lit", done, 1);

    // oversize length 0x0401
    b = '{8'h01, 8'h04};
    run_session(b, 1'b0, 1'b0, "big");
    check("big_nwrites", obs_q.size(), 0);
    check("big_err_lit", err, 1);
    check("big_ready_lit", s_ready, 0);
    check("big_hold_lit", core_hold, 1);

    // N=3 without and with gaps
    b = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hA5, 8'h5A, 8'hC3, 8'h3C};
    run_session(b, 1'b0, 1'b0, "n3_nogap");
    ref_q = obs_q;
    run_session(b, 1'b1, 1'b0, "n3_gap");
    check("gap_nwrites", obs_q.size(), ref_q.size());
    foreach (ref_q[k]) if (k < obs_q.size()) check("gap_vs_nogap", obs_q[k], ref_q[k]);
    check("n3_w2_lit", (ref_q.size() == 3) ? ref_q[2] : '0, {10'd2, 32'h3CC35AA5});

    // reset in the middle of word 0
    pulse_start();
    b = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send(b, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset("midword");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_reset("after_reset");
    b = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_session(b, 1'b0, 1'b0, "post_reset");
    check("post_reset_w0", (obs_q.size() == 1) ? obs_q[0] : '0, {10'd0, 32'h44332211});

    // full depth
    b = '{8'h00, 8'h04};
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] v;
      v = 32'(w) * 32'h9E3779B1;
      b.push_back(v[7:0]);
      b.push_back(v[15:8]);
      b.push_back(v[23:16]);
      b.push_back(v[31:24]);
    end
    run_session(b, 1'b0, 1'b0, "full");
    check("full_nwrites", obs_q.size(), DEPTH);
    check("full_last_addr", (obs_q.size() > 0) ? obs_q[obs_q.size()-1].addr : '0, 10'd1023);

`ifdef SIMPLERISC_LOADER_CHECKSUM_EN
    b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h68};
    run_session(b, 1'b0, 1'b1, "csum_bad");
    check("csum_bad_err_lit", err, 1);
    run_session(b, 1'b0, 1'b0, "csum_good");
    check("csum_good_done_lit", done, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
